// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared core types and constants for the hazard controller
package core_pkg;

  localparam int NREG             = 32;
  localparam int REG_IDX_WIDTH    = $clog2(NREG);
  localparam int FLUSH_CYCLES_MIN = 1;
  localparam int FLUSH_CYCLES_MAX = 7;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

endpackage

// File: rtl/reg_scoreboard.sv
// rtl/reg_scoreboard.sv - per-register in-flight write tracking with write-through RAW lookup
module reg_scoreboard #(
  parameter int NREG = 32,
  parameter int IDXW = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_set_en,
  input  logic [IDXW-1:0] i_set_idx,
  input  logic            i_clr_en,
  input  logic [IDXW-1:0] i_clr_idx,
  input  logic            i_rs1_en,
  input  logic [IDXW-1:0] i_rs1_idx,
  input  logic            i_rs2_en,
  input  logic [IDXW-1:0] i_rs2_idx,
  output logic [NREG-1:0] o_busy,
  output logic [NREG-1:0] o_busy_eff,
  output logic            o_raw,
  output logic            o_any_busy
);

  logic [NREG-1:0] r_busy;
  logic [NREG-1:0] w_set_mask;
  logic [NREG-1:0] w_clr_mask;
  logic [NREG-1:0] w_busy_eff;

  // Index 0 is excluded from both masks, so bit 0 of r_busy can never be set.
  always_comb begin
    w_set_mask = '0;
    w_clr_mask = '0;
    if (i_set_en && (i_set_idx != '0)) w_set_mask[i_set_idx] = 1'b1;
    if (i_clr_en && (i_clr_idx != '0)) w_clr_mask[i_clr_idx] = 1'b1;
  end

  assign w_busy_eff = r_busy & ~w_clr_mask;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_eff | w_set_mask;
    end
  end

  assign o_busy     = r_busy;
  assign o_busy_eff = w_busy_eff;
  assign o_raw      = (i_rs1_en & w_busy_eff[i_rs1_idx]) | (i_rs2_en & w_busy_eff[i_rs2_idx]);
  assign o_any_busy = |w_busy_eff;

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - issue/stall/flush control between decode and ID/EX
module hazard_ctrl #(
  parameter int NREG         = 32,
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_WIDTH    = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    dec_valid_i,
  input  logic [$clog2(NREG)-1:0] dec_rs1_idx_i,
  input  logic [$clog2(NREG)-1:0] dec_rs2_idx_i,
  input  logic                    dec_rs1_en_i,
  input  logic                    dec_rs2_en_i,
  input  logic [$clog2(NREG)-1:0] dec_rd_idx_i,
  input  logic                    dec_rd_en_i,
  input  logic                    dec_csr_i,
  input  logic                    ex_redirect_i,
  input  logic                    wb_rd_en_i,
  input  logic [$clog2(NREG)-1:0] wb_rd_idx_i,
  output logic                    issue_o,
  output logic                    stall_if_o,
  output logic                    flush_if_id_o,
  output logic [NREG-1:0]         busy_o,
  output logic [1:0]              state_o,
  output logic [CNT_WIDTH-1:0]    stall_cnt_o
);
  import core_pkg::*;

  localparam int FLUSH_CLAMP = (FLUSH_CYCLES < FLUSH_CYCLES_MIN) ? FLUSH_CYCLES_MIN :
                               (FLUSH_CYCLES > FLUSH_CYCLES_MAX) ? FLUSH_CYCLES_MAX : FLUSH_CYCLES;
  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CLAMP);

  state_t                 r_state;
  logic [2:0]             r_flush_cnt;
  logic [CNT_WIDTH-1:0]   r_stall_cnt;
  logic [NREG-1:0]        w_busy_eff;
  logic                   w_raw;
  logic                   w_any_busy;
  logic                   w_csr_block;
  logic                   w_issue;
  logic                   w_flush;
  logic                   w_stall;

  reg_scoreboard #(.NREG(NREG), .IDXW($clog2(NREG))) u_sb (
    .clk        (clk),
    .rst        (rst),
    .i_set_en   (w_issue & dec_rd_en_i),
    .i_set_idx  (dec_rd_idx_i),
    .i_clr_en   (wb_rd_en_i),
    .i_clr_idx  (wb_rd_idx_i),
    .i_rs1_en   (dec_rs1_en_i),
    .i_rs1_idx  (dec_rs1_idx_i),
    .i_rs2_en   (dec_rs2_en_i),
    .i_rs2_idx  (dec_rs2_idx_i),
    .o_busy     (busy_o),
    .o_busy_eff (w_busy_eff),
    .o_raw      (w_raw),
    .o_any_busy (w_any_busy)
  );

  assign w_csr_block = dec_csr_i & (|w_busy_eff);

  // A redirect squashes whatever sits in IF/ID regardless of state.
  always_comb begin
    w_issue = 1'b0;
    w_flush = 1'b0;
    if (ex_redirect_i) begin
      w_flush = 1'b1;
    end else begin
      case (r_state)
        ST_RUN:   w_issue = dec_valid_i & ~w_raw & ~w_csr_block;
        ST_FLUSH: w_flush = 1'b1;
        default:  w_issue = 1'b0;
      endcase
    end
  end

  assign w_stall = dec_valid_i & ~w_issue & ~w_flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_RUN;
      r_flush_cnt <= '0;
    end else if (ex_redirect_i) begin
      r_state     <= ST_FLUSH;
      r_flush_cnt <= FLUSH_LOAD;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (dec_valid_i && w_csr_block) r_state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (!w_any_busy) r_state <= ST_RUN;
        end
        ST_FLUSH: begin
          if (r_flush_cnt <= 3'd1) begin
            r_state     <= ST_RUN;
            r_flush_cnt <= '0;
          end else begin
            r_flush_cnt <= r_flush_cnt - 3'd1;
          end
        end
        default: r_state <= ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign issue_o       = w_issue;
  assign stall_if_o    = w_stall;
  assign flush_if_id_o = w_flush;
  assign state_o       = r_state;
  assign stall_cnt_o   = r_stall_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed scoreboard bench for hazard_ctrl (FLUSH_CYCLES=1, CNT_WIDTH=4)
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        dec_valid_i;
  logic [4:0]  dec_rs1_idx_i, dec_rs2_idx_i, dec_rd_idx_i, wb_rd_idx_i;
  logic        dec_rs1_en_i, dec_rs2_en_i, dec_rd_en_i, dec_csr_i;
  logic        ex_redirect_i, wb_rd_en_i;
  logic        issue_o, stall_if_o, flush_if_id_o;
  logic [31:0] busy_o;
  logic [1:0]  state_o;
  logic [3:0]  stall_cnt_o;

  localparam logic [1:0] RUN = 2'd0, DRAIN = 2'd1, FLUSH = 2'd2;

  hazard_ctrl #(.NREG(32), .FLUSH_CYCLES(1), .CNT_WIDTH(4)) dut (
    .clk(clk), .rst(rst), .dec_valid_i(dec_valid_i),
    .dec_rs1_idx_i(dec_rs1_idx_i), .dec_rs2_idx_i(dec_rs2_idx_i),
    .dec_rs1_en_i(dec_rs1_en_i), .dec_rs2_en_i(dec_rs2_en_i),
    .dec_rd_idx_i(dec_rd_idx_i), .dec_rd_en_i(dec_rd_en_i), .dec_csr_i(dec_csr_i),
    .ex_redirect_i(ex_redirect_i), .wb_rd_en_i(wb_rd_en_i), .wb_rd_idx_i(wb_rd_idx_i),
    .issue_o(issue_o), .stall_if_o(stall_if_o), .flush_if_id_o(flush_if_id_o),
    .busy_o(busy_o), .state_o(state_o), .stall_cnt_o(stall_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       issue, stall, flush;
    logic [1:0] state;
    bit         ck_busy;
    logic [31:0] busy;
    bit         ck_cnt;
    logic [3:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_errors++;
      $display("FAIL %s: actual=%0h expected=%0h", nm, act, exp_v);
    end
  endtask

  // Monitor: one expectation per driven cycle, compared mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk({e.name, "/issue"}, 32'(issue_o),       32'(e.issue));
      chk({e.name, "/stall"}, 32'(stall_if_o),    32'(e.stall));
      chk({e.name, "/flush"}, 32'(flush_if_id_o), 32'(e.flush));
      chk({e.name, "/state"}, 32'(state_o),       32'(e.state));
      if (e.ck_busy) chk({e.name, "/busy"}, busy_o, e.busy);
      if (e.ck_cnt)  chk({e.name, "/cnt"}, 32'(stall_cnt_o), 32'(e.cnt));
    end
  end

  task automatic idle();
    dec_valid_i = 0; dec_rs1_idx_i = 0; dec_rs2_idx_i = 0; dec_rd_idx_i = 0;
    dec_rs1_en_i = 0; dec_rs2_en_i = 0; dec_rd_en_i = 0; dec_csr_i = 0;
    ex_redirect_i = 0; wb_rd_en_i = 0; wb_rd_idx_i = 0;
  endtask

  task automatic dec(input logic [4:0] r1, input logic e1, input logic [4:0] r2, input logic e2,
                     input logic [4:0] rd, input logic rde, input logic csr);
    dec_valid_i = 1; dec_rs1_idx_i = r1; dec_rs1_en_i = e1; dec_rs2_idx_i = r2; dec_rs2_en_i = e2;
    dec_rd_idx_i = rd; dec_rd_en_i = rde; dec_csr_i = csr;
  endtask

  task automatic wb(input logic [4:0] idx);
    wb_rd_en_i = 1; wb_rd_idx_i = idx;
  endtask

  task automatic step(input string nm, input logic iss, input logic stl, input logic fl,
                      input logic [1:0] st, input bit ckb, input logic [31:0] b,
                      input bit ckc, input logic [3:0] c);
    exp_t e;
    e.name = nm; e.issue = iss; e.stall = stl; e.flush = fl; e.state = st;
    e.ck_busy = ckb; e.busy = b; e.ck_cnt = ckc; e.cnt = c;
    exp_q.push_back(e);
    @(posedge clk); #1;
    idle();
  endtask

  initial begin
    idle();
    rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;

    step("reset", 0, 0, 0, RUN, 1, 32'h0, 1, 4'd0);
    dec(0, 1, 0, 0, 5, 1, 0);
    step("addi_x5", 1, 0, 0, RUN, 1, 32'h0, 1, 4'd0);
    dec(5, 1, 5, 1, 6, 1, 0);
    step("add_raw", 0, 1, 0, RUN, 1, 32'h20, 1, 4'd0);
    dec(5, 1, 5, 1, 6, 1, 0); wb(5);
    step("add_wbthru", 1, 0, 0, RUN, 1, 32'h20, 1, 4'd1);
    step("after_add", 0, 0, 0, RUN, 1, 32'h40, 1, 4'd1);
    wb(6);
    step("wb_x6", 0, 0, 0, RUN, 1, 32'h40, 1, 4'd1);
    dec(0, 0, 0, 0, 0, 1, 0);
    step("write_x0", 1, 0, 0, RUN, 1, 32'h0, 1, 4'd1);
    dec(0, 1, 0, 1, 0, 0, 0);
    step("read_x0", 1, 0, 0, RUN, 1, 32'h0, 1, 4'd1);
    dec(0, 0, 0, 0, 9, 1, 0); wb(9);
    step("set_clr_x9", 1, 0, 0, RUN, 1, 32'h0, 1, 4'd1);
    step("x9_set_wins", 0, 0, 0, RUN, 1, 32'h200, 1, 4'd1);
    wb(9);
    step("wb_x9", 0, 0, 0, RUN, 1, 32'h200, 1, 4'd1);

    dec(0, 0, 0, 0, 7, 1, 0);
    step("set_x7", 1, 0, 0, RUN, 1, 32'h0, 1, 4'd1);
    dec(0, 0, 0, 0, 0, 0, 1);
    step("csr_blocked", 0, 1, 0, RUN, 1, 32'h80, 1, 4'd1);
    dec(0, 0, 0, 0, 0, 0, 1);
    step("csr_drain", 0, 1, 0, DRAIN, 1, 32'h80, 1, 4'd2);
    dec(0, 0, 0, 0, 0, 0, 1); wb(7);
    step("csr_drain_wb", 0, 1, 0, DRAIN, 1, 32'h80, 1, 4'd3);
    dec(0, 0, 0, 0, 0, 0, 1);
    step("csr_issue", 1, 0, 0, RUN, 1, 32'h0, 1, 4'd4);

    dec(0, 0, 0, 0, 0, 0, 0); ex_redirect_i = 1;
    step("redir", 0, 0, 1, RUN, 0, 0, 1, 4'd4);
    dec(0, 0, 0, 0, 0, 0, 0);
    step("flush1", 0, 0, 1, FLUSH, 0, 0, 1, 4'd4);
    dec(0, 0, 0, 0, 0, 0, 0);
    step("post_flush", 1, 0, 0, RUN, 0, 0, 1, 4'd4);
    dec(0, 0, 0, 0, 0, 0, 0); ex_redirect_i = 1;
    step("redir2", 0, 0, 1, RUN, 0, 0, 0, 0);
    dec(0, 0, 0, 0, 0, 0, 0); ex_redirect_i = 1;
    step("redir_in_flush", 0, 0, 1, FLUSH, 0, 0, 0, 0);
    dec(0, 0, 0, 0, 0, 0, 0);
    step("flush_ext", 0, 0, 1, FLUSH, 0, 0, 0, 0);
    dec(0, 0, 0, 0, 0, 0, 0);
    step("post_flush2", 1, 0, 0, RUN, 0, 0, 1, 4'd4);

    dec(0, 0, 0, 0, 10, 1, 0);
    step("set_x10", 1, 0, 0, RUN, 1, 32'h0, 1, 4'd4);
    for (int k = 0; k < 14; k++) begin
      dec(10, 1, 0, 0, 11, 1, 0);
      step($sformatf("sat%0d", k), 0, 1, 0, RUN, 1, 32'h400, 1, (4 + k > 15) ? 4'd15 : 4'(4 + k));
    end
    dec(0, 0, 0, 0, 0, 0, 1);
    step("csr_x10", 0, 1, 0, RUN, 1, 32'h400, 1, 4'd15);
    dec(0, 0, 0, 0, 0, 0, 1); rst = 1;
    step("drain_rst", 0, 1, 0, DRAIN, 1, 32'h400, 1, 4'd15);
    rst = 0; dec(0, 0, 0, 0, 0, 0, 1);
    step("after_rst", 1, 0, 0, RUN, 1, 32'h0, 1, 4'd0);

    ex_redirect_i = 1;
    step("redir3", 0, 0, 1, RUN, 0, 0, 1, 4'd0);
    rst = 1;
    step("flush_rst", 0, 0, 1, FLUSH, 0, 0, 1, 4'd0);
    rst = 0;
    step("after_rst2", 0, 0, 0, RUN, 1, 32'h0, 1, 4'd0);

    repeat (2) @(posedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
